// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT {cout, sum} adder results into a block total and holds it
// on a valid/ready port, back-pressuring the adder source while it waits.
module adder_result_accumulator #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  logic             r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W:0]   w_sum;
  logic             w_accept;

  assign w_sample = ACC_W'({cout, sum});
  // One extra bit catches the carry out of the accumulator's top bit.
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_sample};

  // Depends only on state and clear, so the source never sees a loop via in_valid.
  assign in_ready = (r_state == ST_ACCUM) && !clear;
  assign w_accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= w_sum[ACC_W-1:0];
      r_overflow <= r_overflow | w_sum[ACC_W];
      if (r_cnt == LAST_CNT) begin
        r_cnt   <= '0;
        r_state <= ST_HOLD;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if ((r_state == ST_HOLD) && out_ready) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign acc_out   = r_acc;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: a default (ACC_W=24) and an ACC_W=18
// instance share stimulus; block totals are scoreboarded against constants.
module tb_adder_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] sum;
  logic        cout;
  logic        clear;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, overflow_a;
  logic [23:0] acc_out_a;
  logic        in_ready_b, out_valid_b, overflow_b;
  logic [17:0] acc_out_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0]       c;
    logic [3:0][15:0] s;
    logic [23:0]      exp_a;
    logic             exp_ovf_a;
    logic [17:0]      exp_b;
    logic             exp_ovf_b;
  } vec_t;

  typedef struct packed {
    logic [23:0] a;
    logic        oa;
    logic [17:0] b;
    logic        ob;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  adder_result_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .sum(sum), .cout(cout), .clear(clear), .out_valid(out_valid_a),
    .out_ready(out_ready), .acc_out(acc_out_a), .overflow(overflow_a)
  );

  adder_result_accumulator #(.ACC_W(18)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .sum(sum), .cout(cout), .clear(clear), .out_valid(out_valid_b),
    .out_ready(out_ready), .acc_out(acc_out_b), .overflow(overflow_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one sample for the coming edge; it must be accepted by both instances.
  task automatic accept(input logic c, input logic [15:0] s);
    @(negedge clk);
    in_valid  = 1'b1;
    cout      = c;
    sum       = s;
    clear     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("in_ready_a on accept", 32'(in_ready_a), 32'd1);
    check("in_ready_b on accept", 32'(in_ready_b), 32'd1);
  endtask

  // Output handshake for the coming edge; compares against the scoreboard head.
  task automatic take(input logic keep_valid, input logic [15:0] keep_sum);
    exp_t e;
    @(negedge clk);
    in_valid  = keep_valid;
    cout      = 1'b0;
    sum       = keep_sum;
    clear     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("out_valid_a in hold", 32'(out_valid_a), 32'd1);
    check("out_valid_b in hold", 32'(out_valid_b), 32'd1);
    check("in_ready_a in hold", 32'(in_ready_a), 32'd0);
    check("in_ready_b in hold", 32'(in_ready_b), 32'd0);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue, expected a pending total");
    end else begin
      e = sb_q.pop_front();
      check("acc_out_a", 32'(acc_out_a), 32'(e.a));
      check("overflow_a", 32'(overflow_a), 32'(e.oa));
      check("acc_out_b", 32'(acc_out_b), 32'(e.b));
      check("overflow_b", 32'(overflow_b), 32'(e.ob));
    end
  endtask

  task automatic push(input logic [23:0] a, input logic oa, input logic [17:0] b, input logic ob);
    exp_t e;
    e.a = a; e.oa = oa; e.b = b; e.ob = ob;
    sb_q.push_back(e);
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{c: 4'b0000, s: {16'd1000, 16'd5, 16'd16, 16'd1},
                exp_a: 24'd1022, exp_ovf_a: 1'b0, exp_b: 18'd1022, exp_ovf_b: 1'b0};
    vecs[1] = '{c: 4'b1111, s: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                exp_a: 24'h07FFFC, exp_ovf_a: 1'b0, exp_b: 18'h3FFFC, exp_ovf_b: 1'b1};
    vecs[2] = '{c: 4'b0000, s: {16'd1, 16'd1, 16'd1, 16'd1},
                exp_a: 24'd4, exp_ovf_a: 1'b0, exp_b: 18'd4, exp_ovf_b: 1'b0};
    vecs[3] = '{c: 4'b1010, s: {16'h8000, 16'h1234, 16'h0000, 16'hFFFF},
                exp_a: 24'h039233, exp_ovf_a: 1'b0, exp_b: 18'h39233, exp_ovf_b: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; sum = '0; cout = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid_a", 32'(out_valid_a), 32'd0);
    check("reset acc_out_a", 32'(acc_out_a), 32'd0);
    check("reset overflow_a", 32'(overflow_a), 32'd0);
    check("reset in_ready_a", 32'(in_ready_a), 32'd1);
    check("reset out_valid_b", 32'(out_valid_b), 32'd0);
    rst_n = 1'b1;

    // Back-to-back table blocks, each followed by an immediate handshake.
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      push(v.exp_a, v.exp_ovf_a, v.exp_b, v.exp_ovf_b);
      for (int k = 0; k < 4; k++) accept(v.c[k], v.s[k]);
      take(1'b0, 16'd0);
    end

    // Back-pressure: in HOLD, in_valid with sum=7 is ignored until the handshake.
    push(24'd4, 1'b0, 18'd4, 1'b0);
    for (int k = 0; k < 4; k++) accept(1'b0, 16'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; cout = 1'b0; sum = 16'd7; out_ready = 1'b0;
      #1;
      check("bp in_ready_a", 32'(in_ready_a), 32'd0);
      check("bp out_valid_a", 32'(out_valid_a), 32'd1);
      check("bp acc_out_a stable", 32'(acc_out_a), 32'd4);
    end
    take(1'b1, 16'd7);
    push(24'd10, 1'b0, 18'd10, 1'b0);
    accept(1'b0, 16'd7);
    for (int k = 0; k < 3; k++) accept(1'b0, 16'd1);
    take(1'b0, 16'd0);

    // Clear mid-block: the sample offered in the clear cycle is dropped.
    accept(1'b0, 16'd10);
    accept(1'b0, 16'd20);
    @(negedge clk);
    in_valid = 1'b1; sum = 16'd30; clear = 1'b1;
    #1;
    check("clear in_ready_a", 32'(in_ready_a), 32'd0);
    check("clear in_ready_b", 32'(in_ready_b), 32'd0);
    push(24'd4, 1'b0, 18'd4, 1'b0);
    for (int k = 0; k < 4; k++) accept(1'b0, 16'd1);
    take(1'b0, 16'd0);

    // Clear in HOLD wins over a simultaneous output handshake.
    for (int k = 0; k < 4; k++) accept(1'b0, 16'd9);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1; out_ready = 1'b1;
    #1;
    check("clear hold out_valid_a", 32'(out_valid_a), 32'd1);
    check("clear hold in_ready_a", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    #1;
    check("after clear out_valid_a", 32'(out_valid_a), 32'd0);
    check("after clear acc_out_a", 32'(acc_out_a), 32'd0);
    check("after clear in_ready_a", 32'(in_ready_a), 32'd1);

    // Asynchronous reset while a total is pending.
    for (int k = 0; k < 4; k++) accept(1'b1, 16'hFFFF);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-reset overflow_b", 32'(overflow_b), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async out_valid_a", 32'(out_valid_a), 32'd0);
    check("async acc_out_a", 32'(acc_out_a), 32'd0);
    check("async overflow_b", 32'(overflow_b), 32'd0);
    check("async acc_out_b", 32'(acc_out_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready_a", 32'(in_ready_a), 32'd1);
    check("post-reset out_valid_b", 32'(out_valid_b), 32'd0);
    push(24'd12, 1'b0, 18'd12, 1'b0);
    for (int k = 0; k < 4; k++) accept(1'b0, 16'd3);
    take(1'b0, 16'd0);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
